burst_write_splitter: RTL and testbench
=======================================

// Module: burst_write_splitter
// PURPOSE
//  Upstream feeder of the burst write pipeline. Accepts one write command (start address plus a beat
//  count of up to 2^CMD_LEN_WIDTH beats) and its data stream. Splits the command into bursts of at most
//  MAX_BURST_LENGTH beats that never cross a BOUNDARY_BYTES address boundary. Drives the pipeline's
//  address channel (addr, length-1) and its data channel.
// PARAMETERS
//  DATA_WIDTH       32    data beat width; BEAT_BYTES = DATA_WIDTH/8 (localparam, power of 2)
//  ADDR_WIDTH       32    byte address width
//  MAX_BURST_LENGTH 4     max beats per emitted burst; power of 2, 1..256
//  CMD_LEN_WIDTH    16    width of command length field (beats-1)
//  BOUNDARY_BYTES   4096  no burst may cross a multiple of this; power of 2, >= MAX_BURST_LENGTH*BEAT_BYTES
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              synchronous, active-low reset
//  c_addr        in   ADDR_WIDTH     command start byte address; bits below BEAT_BYTES treated as 0
//  c_len         in   CMD_LEN_WIDTH  command beats minus 1
//  c_valid       in   1              command valid
//  c_ready       out  1              command ready
//  s_data        in   DATA_WIDTH     write data beat
//  s_valid       in   1              data valid
//  s_ready       out  1              data ready
//  d_addr        out  ADDR_WIDTH     burst start address
//  d_length      out  8              burst beats minus 1
//  d_addr_valid  out  1              burst address valid
//  d_addr_ready  in   1              burst address ready
//  d_data        out  DATA_WIDTH     data beat to pipeline
//  d_data_valid  out  1              data valid to pipeline
//  d_data_ready  in   1              data ready from pipeline
//  busy          out  1              command in progress (state != IDLE)
//  cmd_done      out  1              1-cycle pulse: all bursts and data beats of the command forwarded
// BEHAVIOUR
//  - Reset values:
//    - d_addr_valid=0, d_data_valid=0, d_addr=0, d_length=0, d_data=0, busy=0, cmd_done=0.
//    - c_ready=1, s_ready=0. Internal counters are 0 and state is IDLE.
//  - Handshakes: a transfer occurs on valid&&ready at a rising edge. Once asserted, valid is held and
//    payload is kept stable until accepted.
//  - FSM states are IDLE, ISSUE and DRAIN.
//    - IDLE: c_ready=1. On a command handshake, latch addr (beat-aligned), set addr_left=c_len+1 and
//      data_left=c_len+1, then go to ISSUE.
//    - ISSUE: compute beats = min(addr_left, MAX_BURST_LENGTH, (BOUNDARY_BYTES - addr%BOUNDARY_BYTES)/BEAT_BYTES).
//      - Load the registered d_addr/d_length=beats-1 and raise d_addr_valid.
//      - On each d_addr handshake: addr += beats*BEAT_BYTES, addr_left -= beats.
//      - If addr_left becomes 0, go to DRAIN; otherwise present the next burst on the following cycle.
//    - DRAIN: wait until data_left==0, then pulse cmd_done for one cycle and go to IDLE.
//  - Latency:
//    - Command handshake at edge N puts the first d_addr_valid=1 after edge N+1.
//    - Back-to-back bursts leave at most 1 bubble cycle between d_addr handshakes.
//  - Data path:
//    - s_ready = (data_left>0) && skid buffer can accept. Each s handshake decrements data_left.
//    - Beats pass in order through a 2-entry skid buffer. Full throughput: 1 beat/cycle when
//      d_data_ready=1.
//    - Data is decoupled from the address channel: beats may precede or trail their burst address.
//    - Beats beyond the command's count are never accepted.
//  - A command handshake is not possible while busy=1; c_ready=0 outside IDLE.
//  - cmd_done and the next command's c_ready: cmd_done asserts in the cycle state returns to IDLE.
//    A new command is accepted no earlier than the cycle after cmd_done.
//  - Address arithmetic wraps modulo 2^ADDR_WIDTH; the boundary rule still applies at wrap.
//  - c_len=0 produces exactly one 1-beat burst.
//  - Reset mid-operation returns all state and outputs to reset values on the next edge. In-flight
//    bursts and buffered beats are discarded with no cmd_done.
// STRUCTURE
//  - Shared package burst_pkg:
//    - state enum {IDLE, ISSUE, DRAIN}.
//    - function calc_burst_beats(addr, left, max, boundary, beat_bytes).
//    - beat_bytes localparam helper.
//  - Sub-module burst_skid_buffer #(WIDTH): 2-entry valid/ready skid buffer, registered outputs,
//    valid=0 at reset. Used for the data channel.
// TESTING
//  Config for all scenarios: BEAT_BYTES=4, MAX_BURST_LENGTH=4, BOUNDARY_BYTES=4096.
//  1. Basic split: c_addr=0x100, c_len=9, sinks always ready.
//     -> bursts (0x100,3),(0x110,3),(0x120,1); 10 data beats in order; one cmd_done.
//  2. Boundary: c_addr=0xFF8, c_len=3.
//     -> bursts (0xFF8,1),(0x1000,1); no burst crosses 0x1000.
//  3. Single beat: c_addr=0x40, c_len=0.
//     -> one burst (0x40,0); one data beat; cmd_done; c_ready=1 the following cycle.
//  4. Address stall: d_addr_ready=0 for 3 cycles during burst 2 of scenario 1.
//     -> d_addr/d_length stable; no duplicate or dropped burst.
//  5. Data backpressure: d_data_ready pattern 1,0,1,0,... with continuous s_valid, c_len=9.
//     -> exactly 10 beats out, order preserved; s_ready=0 after the 10th beat until the next command.
//  6. Reset mid-operation: rst_n=0 for 1 cycle after the 2nd burst handshake of scenario 1.
//     -> all outputs at reset values, no cmd_done, c_ready=1 after release.
//     -> a new command then completes normally.

Source files
------------

// File: rtl/burst_pkg.sv
// Shared types and helpers for the burst write splitter: FSM states and the
// per-burst beat-count rule (max length, remaining beats, boundary room).
package burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int unsigned beat_bytes_of(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Beats in the next burst: limited by what is left, by the maximum burst
  // length, and by the room before the next boundary multiple.
  function automatic logic [31:0] calc_burst_beats(
    input logic [31:0] addr,
    input logic [31:0] left,
    input logic [31:0] max_beats,
    input logic [31:0] boundary,
    input logic [31:0] beat_bytes
  );
    logic [31:0] room;
    logic [31:0] beats;
    room  = (boundary - (addr & (boundary - 32'd1))) / beat_bytes;
    beats = left;
    if (max_beats < beats) beats = max_beats;
    if (room < beats) beats = room;
    return beats;
  endfunction

endpackage

// File: rtl/burst_write_splitter_skid.sv
// Two-entry valid/ready skid buffer with registered outputs; keeps full
// throughput while breaking the ready path from downstream to upstream.
module burst_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  output logic             up_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic             dn_valid,
  input  logic             dn_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  assign up_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dn_data    <= '0;
      dn_valid   <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (dn_ready || !dn_valid) begin
      // Output slot frees up: the oldest held beat moves forward first.
      if (skid_valid) begin
        dn_data    <= skid_data;
        dn_valid   <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        dn_valid <= up_valid;
        if (up_valid) dn_data <= up_data;
      end
    end else if (up_valid && up_ready) begin
      skid_data  <= up_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/burst_write_splitter.sv
// Splits one write command into boundary-safe bursts on the address channel
// and forwards the command's data beats through a skid buffer.
module burst_write_splitter
  import burst_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int MAX_BURST_LENGTH = 4,
  parameter int CMD_LEN_WIDTH    = 16,
  parameter int BOUNDARY_BYTES   = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_WIDTH-1:0]    c_addr,
  input  logic [CMD_LEN_WIDTH-1:0] c_len,
  input  logic                     c_valid,
  output logic                     c_ready,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [ADDR_WIDTH-1:0]    d_addr,
  output logic [7:0]               d_length,
  output logic                     d_addr_valid,
  input  logic                     d_addr_ready,
  output logic [DATA_WIDTH-1:0]    d_data,
  output logic                     d_data_valid,
  input  logic                     d_data_ready,
  output logic                     busy,
  output logic                     cmd_done
);

  localparam int BEAT_BYTES = int'(beat_bytes_of(DATA_WIDTH));
  localparam int LEFT_W     = CMD_LEN_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BEAT_BYTES - 1);

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr, addr_n, d_addr_n;
  logic [LEFT_W-1:0]       addr_left, addr_left_n;
  logic [LEFT_W-1:0]       data_left, data_left_n;
  logic [7:0]              d_length_n;
  logic                    d_addr_valid_n, cmd_done_n;
  logic [31:0]             beats;
  logic [8:0]              hs_beats;
  logic                    c_hs, a_hs, s_hs, buf_ready, data_open;

  assign c_ready   = (state == IDLE) && !cmd_done;
  assign busy      = (state != IDLE);
  assign data_open = (data_left != '0);
  assign s_ready   = data_open && buf_ready;
  assign c_hs      = c_valid && c_ready;
  assign a_hs      = d_addr_valid && d_addr_ready;
  assign s_hs      = s_valid && s_ready;

  assign beats    = calc_burst_beats(32'(addr), 32'(addr_left), 32'(MAX_BURST_LENGTH),
                                     32'(BOUNDARY_BYTES), 32'(BEAT_BYTES));
  // Size of the burst currently on the channel, recovered from its length field.
  assign hs_beats = {1'b0, d_length} + 9'd1;

  always_comb begin
    state_n        = state;
    addr_n         = addr;
    addr_left_n    = addr_left;
    data_left_n    = data_left - LEFT_W'(s_hs);
    d_addr_n       = d_addr;
    d_length_n     = d_length;
    d_addr_valid_n = d_addr_valid;
    cmd_done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (c_hs) begin
          addr_n      = c_addr & ALIGN_MASK;
          addr_left_n = {1'b0, c_len} + LEFT_W'(1);
          data_left_n = {1'b0, c_len} + LEFT_W'(1);
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        if (!d_addr_valid) begin
          d_addr_n       = addr;
          d_length_n     = 8'(beats - 32'd1);
          d_addr_valid_n = 1'b1;
        end else if (a_hs) begin
          d_addr_valid_n = 1'b0;
          addr_n         = addr + ADDR_WIDTH'(32'(hs_beats) * 32'(BEAT_BYTES));
          addr_left_n    = addr_left - LEFT_W'(hs_beats);
          if (addr_left == LEFT_W'(hs_beats)) state_n = DRAIN;
        end
      end
      DRAIN: begin
        // Done only once every beat has also left the skid buffer.
        if (!data_open && !d_data_valid) begin
          state_n    = IDLE;
          cmd_done_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      addr_left    <= '0;
      data_left    <= '0;
      d_addr       <= '0;
      d_length     <= '0;
      d_addr_valid <= 1'b0;
      cmd_done     <= 1'b0;
    end else begin
      state        <= state_n;
      addr         <= addr_n;
      addr_left    <= addr_left_n;
      data_left    <= data_left_n;
      d_addr       <= d_addr_n;
      d_length     <= d_length_n;
      d_addr_valid <= d_addr_valid_n;
      cmd_done     <= cmd_done_n;
    end
  end

  burst_skid_buffer #(
    .WIDTH(DATA_WIDTH)
  ) u_data_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .up_data (s_data),
    .up_valid(s_valid && data_open),
    .up_ready(buf_ready),
    .dn_data (d_data),
    .dn_valid(d_data_valid),
    .dn_ready(d_data_ready)
  );

endmodule

// File: tb/tb_burst_write_splitter.sv
// Scoreboard bench for burst_write_splitter: directed scenarios plus random
// commands, checked against a behavioural burst/data model.
module tb_burst_write_splitter;

  localparam int BND = 4096;
  localparam int MBL = 4;
  localparam int BB  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] c_addr;
  logic [15:0] c_len;
  logic        c_valid, c_ready;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic [31:0] d_addr;
  logic [7:0]  d_length;
  logic        d_addr_valid, d_addr_ready;
  logic [31:0] d_data;
  logic        d_data_valid, d_data_ready;
  logic        busy, cmd_done;

  always #5 clk = ~clk;

  burst_write_splitter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST_LENGTH(MBL),
    .CMD_LEN_WIDTH(16), .BOUNDARY_BYTES(BND)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .c_addr(c_addr), .c_len(c_len), .c_valid(c_valid), .c_ready(c_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .d_addr(d_addr), .d_length(d_length), .d_addr_valid(d_addr_valid), .d_addr_ready(d_addr_ready),
    .d_data(d_data), .d_data_valid(d_data_valid), .d_data_ready(d_data_ready),
    .busy(busy), .cmd_done(cmd_done)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  burst_t      exp_burst[$];
  logic [31:0] exp_data[$];
  logic [31:0] src_q[$];

  int vectors = 0, miscompares = 0;
  int pend_done = 0, done_cnt = 0, burst_hs_cnt = 0;
  int data_mode = 0, addr_mode = 0, stall_req = 0;
  bit s_cont = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference model: bursts follow from the start address and beat count alone.
  task automatic push_model(input logic [31:0] a0, input int len);
    logic [31:0] a;
    int left, room, b;
    a    = a0 & ~32'h3;
    left = len + 1;
    while (left > 0) begin
      room = (BND - int'(a % BND)) / BB;
      b = left;
      if (b > MBL) b = MBL;
      if (b > room) b = room;
      exp_burst.push_back('{addr: a, len: 8'(b - 1)});
      a = a + 32'(b * BB);
      left -= b;
    end
  endtask

  // Monitor / scoreboard
  burst_t      eb;
  logic [31:0] ed;
  logic        held;
  logic [39:0] held_val;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_burst.delete();
      exp_data.delete();
      pend_done = 0;
      held = 1'b0;
    end else begin
      if (held) begin
        check("addr_held_valid", d_addr_valid, 1);
        check("addr_held_stable", {d_addr, d_length}, held_val);
      end
      if (d_addr_valid && d_addr_ready) begin
        burst_hs_cnt++;
        check("burst_no_cross", (int'(d_addr % BND) + (int'(d_length) + 1) * BB) > BND, 0);
        check("burst_expected", exp_burst.size() != 0, 1);
        if (exp_burst.size() != 0) begin
          eb = exp_burst.pop_front();
          check("burst_addr", d_addr, eb.addr);
          check("burst_len", d_length, eb.len);
        end
      end
      held     = d_addr_valid && !d_addr_ready;
      held_val = {d_addr, d_length};
      if (d_data_valid && d_data_ready) begin
        check("beat_expected", exp_data.size() != 0, 1);
        if (exp_data.size() != 0) begin
          ed = exp_data.pop_front();
          check("beat_data", d_data, ed);
        end
      end
      if (cmd_done) begin
        check("done_expected", pend_done > 0, 1);
        check("done_bursts_left", exp_burst.size(), 0);
        check("done_beats_left", exp_data.size(), 0);
        if (pend_done > 0) pend_done--;
        done_cnt++;
      end
    end
  end

  // Data source: drives queued beats, holds each until accepted.
  bit hs_d, rst_seen;
  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(negedge clk);
      hs_d     = s_valid && s_ready && rst_n;
      rst_seen = !rst_n;
      @(posedge clk);
      #1;
      if (rst_seen) begin
        src_q.delete();
        s_valid = 1'b0;
      end else begin
        if (hs_d && src_q.size() != 0) void'(src_q.pop_front());
        if (src_q.size() != 0 && ((s_valid && !hs_d) || s_cont || $urandom_range(0, 3) != 0)) begin
          s_valid = 1'b1;
          s_data  = src_q[0];
        end else begin
          s_valid = 1'b0;
          s_data  = '0;
        end
      end
    end
  end

  // Sink ready generators.
  int stall_ack = 0, stall_left = 0;
  initial begin
    d_addr_ready = 1'b1;
    d_data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req != stall_ack) begin
        stall_ack  = stall_req;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        d_addr_ready = 1'b0;
        stall_left--;
      end else begin
        d_addr_ready = (addr_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      case (data_mode)
        0:       d_data_ready = 1'b1;
        1:       d_data_ready = ($urandom_range(0, 2) != 0);
        default: d_data_ready = ~d_data_ready;
      endcase
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_addr_valid", d_addr_valid, 0);
    check("rst_data_valid", d_data_valid, 0);
    check("rst_d_addr", d_addr, 0);
    check("rst_d_length", d_length, 0);
    check("rst_d_data", d_data, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_c_ready", c_ready, 1);
    check("rst_s_ready", s_ready, 0);
  endtask

  task automatic send_cmd(input logic [31:0] a, input int len);
    bit hs;
    int n;
    n = 0;
    @(posedge clk);
    #1;
    c_addr  = a;
    c_len   = 16'(len);
    c_valid = 1'b1;
    do begin
      @(negedge clk);
      hs = c_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 200);
    c_valid = 1'b0;
    if (!hs) timeout("cmd_accept");
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (burst_hs_cnt < target && n < 500) begin
      tick();
      n++;
    end
    if (burst_hs_cnt < target) timeout("burst_handshake");
  endtask

  task automatic run_cmd(input logic [31:0] a, input int len, input bit stall, input bit do_reset);
    int base, d0, n;
    logic [31:0] v;
    base = burst_hs_cnt;
    d0   = done_cnt;
    push_model(a, len);
    for (int i = 0; i <= len; i++) begin
      v = $urandom;
      exp_data.push_back(v);
      src_q.push_back(v);
    end
    pend_done++;
    send_cmd(a, len);
    tick();
    check("first_addr_latency_lo", d_addr_valid, 0);
    tick();
    check("first_addr_latency_hi", d_addr_valid, 1);
    if (stall) begin
      wait_hs(base + 1);
      stall_req++;
    end
    if (do_reset) begin
      wait_hs(base + 2);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check_reset_state();
      tick();
      check("no_done_after_reset", cmd_done, 0);
      check("c_ready_after_reset", c_ready, 1);
    end else begin
      n = 0;
      while (done_cnt == d0 && n < 3000) begin
        tick();
        n++;
      end
      if (done_cnt == d0) begin
        timeout("cmd_done");
      end else begin
        check("c_ready_in_done_cycle", c_ready, 0);
        check("busy_in_done_cycle", busy, 0);
        tick();
        check("c_ready_after_done", c_ready, 1);
        check("s_ready_after_done", s_ready, 0);
        check("done_is_pulse", cmd_done, 0);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    rst_n   = 1'b0;
    c_valid = 1'b0;
    c_addr  = '0;
    c_len   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check_reset_state();

    run_cmd(32'h100, 9, 1'b0, 1'b0);
    run_cmd(32'hFF8, 3, 1'b0, 1'b0);
    run_cmd(32'h40, 0, 1'b0, 1'b0);
    run_cmd(32'h100, 9, 1'b1, 1'b0);
    data_mode = 2;
    s_cont    = 1'b1;
    run_cmd(32'h200, 9, 1'b0, 1'b0);
    data_mode = 0;
    s_cont    = 1'b0;
    run_cmd(32'h100, 9, 1'b0, 1'b1);
    run_cmd(32'h300, 9, 1'b0, 1'b0);
    run_cmd(32'hFFFF_FFF8, 5, 1'b0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      addr_mode = int'($urandom_range(0, 1));
      data_mode = int'($urandom_range(0, 2));
      s_cont    = 1'($urandom_range(0, 1));
      r = $urandom;
      case ($urandom_range(0, 2))
        0:       r = {r[31:12], 12'hFC0 | (r[11:0] & 12'h03F)};
        1:       r = 32'hFFFF_FFC0 | (r & 32'h3F);
        default: r = r;
      endcase
      run_cmd(r, int'($urandom_range(0, 40)), 1'b0, 1'b0);
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
